// File: rtl/fetch_unit.sv
// Instruction fetch: owns the fetch PC, one outstanding imem read, redirect kill, one-entry response buffer.
// Latency is memory latency + 1 cycle to instrF; stallF holds the output and parks at most one response in the buffer.
module fetch_unit #(
  parameter int unsigned      WIDTH    = 32,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallF,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_ready,
  input  logic [WIDTH-1:0] imem_rdata,
  output logic [WIDTH-1:0] instrF,
  output logic [WIDTH-1:0] pcF,
  output logic             instr_validF
);

  localparam logic [WIDTH-1:0] ALIGN_MASK = ~WIDTH'(3);
  localparam logic [WIDTH-1:0] PC_STEP    = WIDTH'(4);

  typedef enum logic [1:0] {S_BOOT, S_REQ, S_WAIT, S_HOLD} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] fetch_pc_q, fetch_pc_d;
  logic [WIDTH-1:0] instr_q, instr_d;
  logic [WIDTH-1:0] pc_q, pc_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] buf_instr_q, buf_instr_d;
  logic [WIDTH-1:0] buf_pc_q, buf_pc_d;
  logic             buf_vld_q, buf_vld_d;
  logic             kill_q, kill_d;
  logic             req_q;
  logic             out_free;
  logic [WIDTH-1:0] redirect_tgt;

  assign redirect_tgt = redirect_pc & ALIGN_MASK;
  assign out_free     = !stallF || !vld_q;

  always_comb begin
    state_d     = state_q;
    fetch_pc_d  = fetch_pc_q;
    instr_d     = instr_q;
    pc_d        = pc_q;
    vld_d       = vld_q;
    buf_instr_d = buf_instr_q;
    buf_pc_d    = buf_pc_q;
    buf_vld_d   = buf_vld_q;
    kill_d      = kill_q;

    // Once IF/ID consumes, the output falls back to a bubble unless refilled below.
    if (!stallF) begin
      instr_d = '0;
      vld_d   = 1'b0;
    end

    case (state_q)
      S_BOOT: state_d = S_REQ;
      S_REQ:  state_d = S_WAIT;
      S_WAIT: begin
        if (imem_ready) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = S_REQ;
          end else if (out_free) begin
            instr_d    = imem_rdata;
            pc_d       = fetch_pc_q;
            vld_d      = 1'b1;
            fetch_pc_d = fetch_pc_q + PC_STEP;
            state_d    = S_REQ;
          end else begin
            buf_instr_d = imem_rdata;
            buf_pc_d    = fetch_pc_q;
            buf_vld_d   = 1'b1;
            fetch_pc_d  = fetch_pc_q + PC_STEP;
            state_d     = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!stallF && buf_vld_q) begin
          instr_d   = buf_instr_q;
          pc_d      = buf_pc_q;
          vld_d     = 1'b1;
          buf_vld_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      default: state_d = S_BOOT;
    endcase

    // Redirect wins over stall and any delivery; an in-flight read must be killed, not reissued.
    if (redirect_valid) begin
      fetch_pc_d = redirect_tgt;
      instr_d    = '0;
      vld_d      = 1'b0;
      pc_d       = pc_q;
      buf_vld_d  = 1'b0;
      case (state_q)
        S_REQ: begin
          kill_d  = 1'b1;
          state_d = S_WAIT;
        end
        S_WAIT: begin
          kill_d  = !imem_ready;
          state_d = imem_ready ? S_REQ : S_WAIT;
        end
        default: begin
          kill_d  = 1'b0;
          state_d = S_REQ;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_BOOT;
      fetch_pc_q  <= RESET_PC;
      instr_q     <= '0;
      pc_q        <= RESET_PC;
      vld_q       <= 1'b0;
      buf_instr_q <= '0;
      buf_pc_q    <= '0;
      buf_vld_q   <= 1'b0;
      kill_q      <= 1'b0;
      req_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      fetch_pc_q  <= fetch_pc_d;
      instr_q     <= instr_d;
      pc_q        <= pc_d;
      vld_q       <= vld_d;
      buf_instr_q <= buf_instr_d;
      buf_pc_q    <= buf_pc_d;
      buf_vld_q   <= buf_vld_d;
      kill_q      <= kill_d;
      req_q       <= (state_d == S_REQ);
    end
  end

  assign imem_req     = req_q;
  assign imem_addr    = fetch_pc_q & ALIGN_MASK;
  assign instrF       = instr_q;
  assign pcF          = pc_q;
  assign instr_validF = vld_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: variable-latency memory model, queued expected requests and deliveries.
module tb_fetch_unit;

  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst;
  logic         stallF;
  logic         redirect_valid;
  logic [W-1:0] redirect_pc;
  logic         imem_req;
  logic [W-1:0] imem_addr;
  logic         imem_ready;
  logic [W-1:0] imem_rdata;
  logic [W-1:0] instrF;
  logic [W-1:0] pcF;
  logic         instr_validF;

  int n_checks = 0;
  int n_fail   = 0;

  logic [W-1:0]   exp_addr_q[$];
  logic [2*W-1:0] exp_instr_q[$];

  int           lat = 1;
  logic         mem_pend = 1'b0;
  int           mem_cnt = 0;
  logic [W-1:0] mem_addr_r = '0;

  fetch_unit #(.WIDTH(W), .RESET_PC(32'h0000_0000)) dut (
    .clk           (clk),
    .rst           (rst),
    .stallF        (stallF),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .instrF        (instrF),
    .pcF           (pcF),
    .instr_validF  (instr_validF)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input string name, input int bound);
    int n = 0;
    while (!instr_validF && n < bound) begin
      tick();
      n++;
    end
    if (!instr_validF) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no instr_validF within %0d cycles", name, bound);
    end
  endtask

  task automatic wait_req(input string name, input int bound);
    int n = 0;
    while (!imem_req && n < bound) begin
      tick();
      n++;
    end
    if (!imem_req) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: no imem_req within %0d cycles", name, bound);
    end
  endtask

  // Memory: answers each request after 'lat' cycles with DEAD_0000 | addr; it keeps answering across a DUT reset.
  initial begin
    imem_ready = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      imem_ready = 1'b0;
      if (mem_pend) begin
        if (mem_cnt <= 1) begin
          imem_ready = 1'b1;
          imem_rdata = 32'hDEAD_0000 | mem_addr_r;
          mem_pend   = 1'b0;
        end else begin
          mem_cnt--;
        end
      end
      if (imem_req) begin
        mem_pend   = 1'b1;
        mem_cnt    = lat;
        mem_addr_r = imem_addr;
      end
    end
  end

  // Monitor: every request and every consumed instruction is matched against the queues.
  initial begin
    logic [2*W-1:0] e;
    forever begin
      @(negedge clk);
      if (rst) begin
        if (imem_req) begin
          if (exp_addr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL req_unexpected: got addr %h, none expected", imem_addr);
          end else begin
            check("imem_addr", imem_addr, exp_addr_q.pop_front());
          end
        end
        if (instr_validF && !stallF) begin
          if (exp_instr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL instr_unexpected: got pc %h instr %h, none expected", pcF, instrF);
          end else begin
            e = exp_instr_q.pop_front();
            check("deliver_pcF", pcF, e[2*W-1:W]);
            check("deliver_instrF", instrF, e[W-1:0]);
          end
        end
        if (!instr_validF) check("bubble_instrF", instrF, '0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int reqs;
    rst            = 1'b0;
    stallF         = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    tick();
    tick();
    check("rst_instrF", instrF, '0);
    check("rst_pcF", pcF, 32'h0);
    check("rst_valid", W'(instr_validF), 32'd0);
    check("rst_req", W'(imem_req), 32'd0);

    // Zero-wait memory: 0,4,8 with valid alternating.
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_addr_q.push_back(32'h8);
    exp_instr_q.push_back({32'h0, 32'hDEAD_0000});
    exp_instr_q.push_back({32'h4, 32'hDEAD_0004});
    exp_instr_q.push_back({32'h8, 32'hDEAD_0008});
    rst = 1'b1;
    wait_req("first_req", 5);
    check("first_addr", imem_addr, 32'h0);
    wait_valid("first_valid", 5);
    check("first_pcF", pcF, 32'h0);
    check("first_instrF", instrF, 32'hDEAD_0000);
    tick();
    check("alt_bubble", W'(instr_validF), 32'd0);
    tick();
    check("alt_valid", W'(instr_validF), 32'd1);
    check("alt_pcF", pcF, 32'h4);
    check("alt_req", W'(imem_req), 32'd1);
    check("alt_addr", imem_addr, 32'h8);

    // Stall 5 cycles; response for pc 8 lands mid-stall and is parked.
    lat    = 3;
    stallF = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      tick();
      check("stall_pcF", pcF, 32'h4);
      check("stall_instrF", instrF, 32'hDEAD_0004);
      check("stall_valid", W'(instr_validF), 32'd1);
      check("stall_noreq", W'(imem_req), 32'd0);
    end
    check("stall_hold_state", W'(dut.state_q), 32'd3);
    exp_addr_q.push_back(32'hC);
    exp_addr_q.push_back(32'h10);
    exp_instr_q.push_back({32'hC, 32'hDEAD_000C});
    tick();
    stallF = 1'b0;
    check("release_pcF", pcF, 32'h4);
    tick();
    check("unpark_pcF", pcF, 32'h8);
    check("unpark_valid", W'(instr_validF), 32'd1);
    check("unpark_req", W'(imem_req), 32'd1);
    check("unpark_addr", imem_addr, 32'hC);

    // Latency 3: one request per 4 cycles, bubbles in between.
    reqs = 0;
    for (int k = 0; k < 6; k++) begin
      if (k > 0) tick();
      if (imem_req) reqs++;
      check("lat3_valid", W'(instr_validF), W'(k == 0 || k == 4));
    end
    check("lat3_req_count", W'(reqs), 32'd2);

    // Redirect while waiting on pc 16: late response dropped, refetch from 0x100.
    exp_addr_q.push_back(32'h100);
    exp_addr_q.push_back(32'h104);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    tick();
    redirect_valid = 1'b0;
    check("kill_valid", W'(instr_validF), 32'd0);
    tick();
    check("redir_req", W'(imem_req), 32'd1);
    check("redir_addr", imem_addr, 32'h100);
    check("redir_bubble", W'(instr_validF), 32'd0);
    wait_valid("redir_valid", 8);
    check("redir_pcF", pcF, 32'h100);
    check("redir_instrF", instrF, 32'hDEAD_0100);
    check("redir_next_addr", imem_addr, 32'h104);

    // Redirect coinciding with imem_ready under stall: data discarded, held output dropped.
    stallF = 1'b1;
    tick();
    tick();
    check("held_pcF", pcF, 32'h100);
    check("held_valid", W'(instr_validF), 32'd1);
    exp_addr_q.push_back(32'h200);
    tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0201;
    tick();
    redirect_valid = 1'b0;
    stallF         = 1'b0;
    check("rr_valid", W'(instr_validF), 32'd0);
    check("rr_instrF", instrF, '0);
    check("rr_pcF", pcF, 32'h100);
    check("rr_req", W'(imem_req), 32'd1);
    check("rr_addr", imem_addr, 32'h200);

    // Asynchronous reset while waiting; stale response arrives after release.
    tick();
    rst = 1'b0;
    #1;
    check("arst_instrF", instrF, '0);
    check("arst_pcF", pcF, 32'h0);
    check("arst_valid", W'(instr_validF), 32'd0);
    check("arst_req", W'(imem_req), 32'd0);
    exp_addr_q.push_back(32'h0);
    exp_addr_q.push_back(32'h4);
    exp_instr_q.push_back({32'h0, 32'hDEAD_0000});
    tick();
    rst = 1'b1;
    wait_req("post_rst_req", 5);
    check("post_rst_addr", imem_addr, 32'h0);
    wait_valid("post_rst_valid", 8);
    check("post_rst_pcF", pcF, 32'h0);
    check("post_rst_instrF", instrF, 32'hDEAD_0000);
    check("post_rst_next_addr", imem_addr, 32'h4);

    @(negedge clk);
    #1;
    check("addr_q_drained", W'(exp_addr_q.size()), 32'd0);
    check("instr_q_drained", W'(exp_instr_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
Instruction-fetch stage that sits directly upstream of the IF/ID pipeline register. It owns the fetch PC, issues one-outstanding-request reads to a variable-latency instruction memory, and absorbs a response that arrives while the pipeline is stalled. It presents instrF/pcF to IF/ID, inserting zero-word bubbles when no instruction is ready, and applies branch/jump redirects from later stages.

Parameters:
WIDTH, 32, instruction/address word width
RESET_PC, 32'h0000_0000, first fetch address after reset

Ports:
clk  input  1  clock, rising edge
rst  input  1  asynchronous active-low reset
stallF  input  1  1 = IF/ID not consuming this cycle; output registers hold
redirect_valid  input  1  single-cycle redirect request from a later stage
redirect_pc  input  WIDTH  redirect target; bits [1:0] ignored, forced to 00
imem_req  output  1  read request, one cycle per request
imem_addr  output  WIDTH  word-aligned read address, valid while imem_req=1
imem_ready  input  1  response valid this cycle
imem_rdata  input  WIDTH  response data, valid when imem_ready=1
instrF  output  WIDTH  instruction to IF/ID; zero word when instr_validF=0
pcF  output  WIDTH  address of instrF
instr_validF  output  1  instrF holds a real fetched instruction

Behaviour:
- Reset (rst=0, async): state=S_BOOT, fetch_pc=RESET_PC, instrF=0, pcF=RESET_PC, instr_validF=0, imem_req=0, buffer empty, kill=0.
- Consume rule: every clock with stallF=0, IF/ID captures instrF. The output register then loads the next ready instruction if one is available, otherwise a bubble (instrF=0, valid=0, pcF unchanged). With stallF=1 the output register holds.
- States:
  - S_BOOT: -> S_REQ (one idle cycle after reset release).
  - S_REQ: imem_req=1, imem_addr=fetch_pc -> S_WAIT. Memory accepts unconditionally.
  - S_WAIT: imem_req=0.
    - On imem_ready with kill=1: drop the data, clear kill, -> S_REQ.
    - On imem_ready with kill=0 and output free (stallF=0 or instr_validF=0): output <= {imem_rdata, fetch_pc, valid=1}; fetch_pc += 4; -> S_REQ.
    - On imem_ready with kill=0 and output occupied and stalled: buffer <= {imem_rdata, fetch_pc}; fetch_pc += 4; -> S_HOLD.
  - S_HOLD: on stallF=0, output <= buffer, buffer empty -> S_REQ.
- Minimum latency: request to instrF valid = memory latency + 1 cycle. Zero-wait memory (ready the cycle after request) gives one instruction every 2 cycles.
- Redirect (redirect_valid=1) overrides stallF and all other events in the same cycle:
  - fetch_pc <= {redirect_pc[WIDTH-1:2], 2'b00}.
  - Output becomes a bubble (instrF=0, valid=0); buffer discarded.
  - From S_REQ: the request issued this cycle is in flight, so kill=1 and go to S_WAIT.
  - From S_WAIT without imem_ready: kill=1, stay in S_WAIT.
  - From S_WAIT with imem_ready: discard the data, -> S_REQ.
  - From S_BOOT or S_HOLD: -> S_REQ.
  - A redirect while kill=1 only updates fetch_pc.
- Arithmetic: fetch_pc+4 wraps modulo 2^WIDTH. imem_addr[1:0] is always 00.
- Never more than one outstanding request. imem_ready outside S_WAIT is ignored.
- Reset asserted mid-request: state returns to reset values immediately. A later stray imem_ready is ignored because the block is not in S_WAIT.

Test Plan:
- Reset release, zero-wait memory, stallF=0: imem_addr sequence 0,4,8. instrF shows each word, pcF=0,4,8, with instr_validF alternating 1/0 every cycle.
- Memory latency 3 cycles: exactly one imem_req per 4 cycles. Bubbles (instrF=0, valid=0) on non-delivery cycles. No second request while waiting.
- stallF=1 held for 5 cycles with the response for pc=8 arriving mid-stall: instrF/pcF unchanged during the stall, state=S_HOLD, no new request. First cycle after release shows pc=8; then a request to 12 is issued.
- redirect_valid with redirect_pc=32'h0000_0103 while waiting on pc=16: the late response is dropped. The next request goes to 0x100 and instrF=0 until the 0x100 data arrives.
- Redirect in the same cycle as imem_ready and stallF=1: the data is discarded, valid=0, and the next request goes to the redirect target.
- rst pulsed low while in S_WAIT: outputs return to reset values asynchronously. After release, the first imem_addr is RESET_PC and the stale imem_ready is ignored.
